// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: operand A latched from the bus, register/immediate ops on start,
// shifts iterate one bit per cycle; result and flags held until the next accepted start.
module seq_alu_core #(
    parameter int N    = 10,
    parameter int IMMW = 6
) (
    input  logic         CLKb,
    input  logic         RST,
    input  logic [N-1:0] OP,
    input  logic [3:0]   FN,
    input  logic         Ain,
    input  logic         start,
    input  logic         Gout,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] RES,
    output logic [3:0]   flags
);
    localparam int SHW = $clog2(N + 1);

    localparam logic [3:0] FN_ADD = 4'b0010;
    localparam logic [3:0] FN_SUB = 4'b0011;
    localparam logic [3:0] FN_NEG = 4'b0100;
    localparam logic [3:0] FN_NOT = 4'b0101;
    localparam logic [3:0] FN_AND = 4'b0110;
    localparam logic [3:0] FN_OR  = 4'b0111;
    localparam logic [3:0] FN_XOR = 4'b1000;
    localparam logic [3:0] FN_LSL = 4'b1001;
    localparam logic [3:0] FN_LSR = 4'b1010;
    localparam logic [3:0] FN_ASR = 4'b1011;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, g_q;
    logic [3:0]     fn_q, flags_q;
    logic [SHW-1:0] cnt_q;
    logic           err_q;

    logic           imm_mode, shift_op, alu_c, alu_v, alu_ill;
    logic [N-1:0]   opnd, alu_g, sh_g;
    logic [3:0]     eff_fn;
    logic [N:0]     sum, diff;
    logic [SHW-1:0] k;

    // Start-time ALU: immediate mode overrides FN with ADD/SUB of the zero-extended field.
    always_comb begin
        imm_mode = OP[N-1];
        opnd     = imm_mode ? N'(OP[IMMW-1:0]) : OP;
        eff_fn   = imm_mode ? (OP[N-2] ? FN_SUB : FN_ADD) : FN;
        sum      = {1'b0, a_q} + {1'b0, opnd};
        diff     = {1'b0, a_q} - {1'b0, opnd};
        k        = (OP[SHW-1:0] > SHW'(N)) ? SHW'(N) : OP[SHW-1:0];
        shift_op = 1'b0;
        alu_g    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_ill  = 1'b0;
        case (eff_fn)
            FN_ADD: begin
                alu_g = sum[N-1:0];
                alu_c = sum[N];
                alu_v = (a_q[N-1] == opnd[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            FN_SUB: begin
                alu_g = diff[N-1:0];
                alu_c = diff[N];
                alu_v = (a_q[N-1] != opnd[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            FN_NEG: alu_g = '0 - a_q;
            FN_NOT: alu_g = ~a_q;
            FN_AND: alu_g = a_q & opnd;
            FN_OR:  alu_g = a_q | opnd;
            FN_XOR: alu_g = a_q ^ opnd;
            FN_LSL, FN_LSR, FN_ASR: begin
                shift_op = 1'b1;
                alu_g    = a_q;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (fn_q)
            FN_LSL:  sh_g = {g_q[N-2:0], 1'b0};
            FN_LSR:  sh_g = {1'b0, g_q[N-1:1]};
            default: sh_g = {g_q[N-1], g_q[N-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (shift_op && k != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKb) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLKb) begin
        if (RST) begin
            a_q     <= '0;
            g_q     <= '0;
            fn_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fn_q    <= FN;
                        cnt_q   <= k;
                        err_q   <= alu_ill;
                        g_q     <= alu_g;
                        flags_q <= alu_ill ? 4'b0000 : {alu_g == '0, alu_g[N-1], alu_c, alu_v};
                    end else if (Ain) begin
                        a_q <= OP;
                    end
                end
                SHIFT: begin
                    g_q     <= sh_g;
                    cnt_q   <= cnt_q - SHW'(1);
                    flags_q <= {sh_g == '0, sh_g[N-1], 2'b00};
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign flags = flags_q;
    assign RES   = Gout ? g_q : '0;
endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core: transaction-level reference model with a per-cycle compare,
// directed ops with hand-computed results, then randomized traffic.
module tb_seq_alu_core;
    localparam int N    = 10;
    localparam int IMMW = 6;
    localparam int SHW  = $clog2(N + 1);
    localparam int M    = 1 << N;

    logic         CLKb = 1'b0, RST = 1'b1, Ain = 1'b0, start = 1'b0, Gout = 1'b0;
    logic [N-1:0] OP = '0;
    logic [3:0]   FN = '0;
    logic         busy, done, err;
    logic [N-1:0] RES;
    logic [3:0]   flags;

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    int m_a = 0, m_g = 0, m_f = 0, m_left = 0;
    bit m_err = 1'b0, m_act = 1'b0;

    always #5 CLKb = ~CLKb;

    seq_alu_core #(.N(N), .IMMW(IMMW)) dut (
        .CLKb(CLKb), .RST(RST), .OP(OP), .FN(FN), .Ain(Ain), .start(start), .Gout(Gout),
        .busy(busy), .done(done), .err(err), .RES(RES), .flags(flags)
    );

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Result of one op from the arithmetic rules; lat is the cycle count until done.
    task automatic model_op(input int a, input int op, input int fn,
                            output int g, output int f, output bit e, output int lat);
        int r, sr, kk, imm;
        bit c, v;
        e = 0; c = 0; v = 0; lat = 1; r = 0; sr = 0;
        if (op >= M / 2) begin
            imm = op % (1 << IMMW);
            if (op >= 3 * M / 4) begin
                r = a - imm; c = (a < imm); sr = sgn(a) - imm;
            end else begin
                r = a + imm; c = (r >= M); sr = sgn(a) + imm;
            end
            v = (sr < -M / 2) || (sr >= M / 2);
        end else begin
            case (fn)
                2: begin r = a + op; c = (r >= M); sr = sgn(a) + sgn(op);
                         v = (sr < -M / 2) || (sr >= M / 2); end
                3: begin r = a - op; c = (a < op); sr = sgn(a) - sgn(op);
                         v = (sr < -M / 2) || (sr >= M / 2); end
                4: r = -a;
                5: r = ~a;
                6: r = a & op;
                7: r = a | op;
                8: r = a ^ op;
                9, 10, 11: begin
                    kk = op % (1 << SHW);
                    if (kk > N) kk = N;
                    lat = 1 + kk;
                    if (fn == 9)       r = a << kk;
                    else if (fn == 10) r = a >> kk;
                    else               r = sgn(a) >>> kk;
                end
                default: begin e = 1; r = 0; end
            endcase
        end
        g = ((r % M) + M) % M;
        f = e ? 0 : ((g == 0) ? 8 : 0) + ((g >= M / 2) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
    endtask

    always @(posedge CLKb) begin
        int g, f, lat;
        bit e;
        if (RST) begin
            m_a = 0; m_g = 0; m_f = 0; m_err = 0; m_act = 0; m_left = 0;
        end else if (m_act) begin
            if (m_left == 0) m_act = 0;
            else             m_left--;
        end else if (start) begin
            model_op(m_a, int'(OP), int'(FN), g, f, e, lat);
            m_g = g; m_f = f; m_err = e; m_act = 1; m_left = lat - 1;
        end else if (Ain) begin
            m_a = int'(OP);
        end
    end

    always @(negedge CLKb) begin
        bit eb;
        if (chk_en) begin
            eb = m_act && (m_left > 0);
            check("busy", int'(busy), int'(eb));
            check("done", int'(done), int'(m_act && m_left == 0));
            check("err", int'(err), int'(m_err));
            if (!eb) begin
                check("res", int'(RES), Gout ? m_g : 0);
                check("flags", int'(flags), m_f);
            end
        end
    end

    task automatic step;
        @(posedge CLKb);
        #2;
    endtask

    task automatic run_op(input bit load, input int a, input int fn, input int op,
                          output int lat, output int bc);
        step;
        if (load) begin
            Ain = 1; OP = N'(a); step; Ain = 0;
        end
        start = 1; FN = 4'(fn); OP = N'(op); step; start = 0;
        lat = 1; bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            step;
            lat++;
        end
        check("done_seen", int'(done), 1);
    endtask

    initial begin
        int lat, bc, npulse;
        step; step;
        chk_en = 1;
        Gout = 1; #1;
        check("rst_res", int'(RES), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        RST = 0;

        run_op(1, 700, 2, 400, lat, bc);
        check("add_lat", lat, 1);
        check("add_g", int'(RES), 76);
        check("add_flags", int'(flags), 4'b0010);

        Gout = 0;
        run_op(1, 5, 3, 7, lat, bc);
        check("sub_gout0", int'(RES), 0);
        Gout = 1; #1;
        check("sub_g", int'(RES), 1022);
        check("sub_flags", int'(flags), 4'b0110);

        run_op(1, 'h200, 11, 3, lat, bc);
        check("asr3_lat", lat, 4);
        check("asr3_busy", bc, 3);
        check("asr3_g", int'(RES), 'h3C0);
        run_op(1, 'h200, 11, 15, lat, bc);
        check("asr15_lat", lat, 11);
        check("asr15_g", int'(RES), 'h3FF);
        check("asr15_flags", int'(flags), 4'b0100);

        run_op(1, 100, 0, 10'b10_0000_1111, lat, bc);
        check("addi_g", int'(RES), 115);
        run_op(1, 10, 0, 10'b11_0000_1111, lat, bc);
        check("subi_g", int'(RES), 1019);
        check("subi_flags", int'(flags), 4'b0110);

        run_op(1, 0, 4, 0, lat, bc);
        check("neg0_g", int'(RES), 0);
        check("neg0_flags", int'(flags), 4'b1000);
        run_op(1, 3, 9, 0, lat, bc);
        check("lsl0_lat", lat, 1);
        check("lsl0_g", int'(RES), 3);

        // Reset in the middle of an 8-step shift.
        step;
        Ain = 1; OP = N'(1); step; Ain = 0;
        start = 1; FN = 4'd9; OP = N'(8); step; start = 0;
        step; step;
        RST = 1; step; RST = 0; #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_res", int'(RES), 0);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) npulse++;
            step;
        end
        check("abort_no_done", npulse, 0);

        // Ain/start during busy are dropped.
        Ain = 1; OP = N'(77); step; Ain = 0;
        start = 1; FN = 4'd10; OP = N'(4); step;
        Ain = 1; start = 1; FN = 4'd2; OP = N'(500); step; step;
        Ain = 0; start = 0;
        lat = 0;
        while (!done && lat < 40) begin step; lat++; end
        check("busy_ign_done", int'(done), 1);
        check("lsr4_g", int'(RES), 4);
        run_op(0, 0, 5, 0, lat, bc);
        check("not_keepA", int'(RES), 946);

        run_op(1, 5, 15, 3, lat, bc);
        check("ill_err", int'(err), 1);
        check("ill_g", int'(RES), 0);
        check("ill_flags", int'(flags), 0);
        run_op(0, 0, 2, 3, lat, bc);
        check("err_clr", int'(err), 0);
        check("add_after_ill", int'(RES), 8);
        step;
        Ain = 1; start = 1; FN = 4'd2; OP = N'(3); step; Ain = 0; start = 0;
        check("ain_start_done", int'(done), 1);
        check("ain_start_oldA", int'(RES), 8);

        for (int i = 0; i < 3000; i++) begin
            RST   = ($urandom_range(0, 299) == 0);
            Ain   = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 2) == 0);
            FN    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(9, 11)) : 4'($urandom_range(0, 15));
            OP    = N'($urandom);
            Gout  = ($urandom_range(0, 3) != 0);
            step;
        end
        RST = 0; Ain = 0; start = 0;
        for (int i = 0; i < 15; i++) step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
